uart_cmd_parser: RTL and testbench
==================================

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 4, number of LED outputs (legal range 1..9).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, inter-byte idle limit in clk cycles (10 ms at 100 MHz).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rx_valid  input  1  one-cycle strobe from the UART receiver, marking rx_data as a new byte.
REQ-006 SHALL have port rx_data  input  8  received byte, sampled only when rx_valid=1.
REQ-007 SHALL have port tx_busy  input  1  UART transmitter busy; a send is legal only when tx_busy=0.
REQ-008 SHALL have port tx_send  output  1  one-cycle request to transmit tx_data.
REQ-009 SHALL have port tx_data  output  8  response byte, stable while tx_send=1.
REQ-010 SHALL have port led  output  NUM_LEDS  registered LED states.
REQ-011 SHALL have port cmd_count  output  8  count of successfully executed commands; wraps 255->0.

Function
REQ-012 SHALL accept the command grammar 'L' (0x4C), index digit, action, CR (0x0D).
- Index digit: '1'..('0'+NUM_LEDS), selecting led[digit-'1'].
- Action: '0' clears, '1' sets, 'T' (0x54) toggles.
REQ-013 SHALL implement the states IDLE, GOT_L, GOT_IDX, GOT_ACT, DISCARD and RESP.
REQ-014 SHALL follow these transitions on rx_valid=1:
- IDLE: 'L' -> GOT_L; CR or LF (0x0A) -> IDLE, no response; any other byte -> DISCARD.
- GOT_L: valid index -> GOT_IDX; else -> DISCARD.
- GOT_IDX: valid action -> GOT_ACT; else -> DISCARD.
- GOT_ACT: CR -> RESP with response 'K' (0x4B); else -> DISCARD.
- DISCARD: CR -> RESP with response 'E' (0x45); other bytes stay in DISCARD.
REQ-015 SHALL update led and increment cmd_count in the cycle after the accepting CR strobe (one-cycle latency).
- Leave all other LED bits unchanged.
REQ-016 SHALL in RESP hold tx_data and assert tx_send for exactly one cycle, in the first cycle in which tx_busy=0, then return to IDLE.
REQ-017 SHALL assert tx_send no earlier than the cycle after entering RESP.
REQ-018 SHALL drop bytes arriving while in RESP, with no state change and no effect on LEDs.
REQ-019 SHALL never assert tx_send outside RESP.
REQ-020 SHALL keep tx_data stable from RESP entry until tx_send has been issued.

Reset
REQ-021 SHALL on rst_n=0 immediately force:
- state=IDLE
- led=0
- cmd_count=0
- tx_send=0
- tx_data=0x00
- timeout counter=0
REQ-022 SHALL, when reset is asserted mid-command or mid-RESP, discard the partial command and send no response after release.

Configuration
REQ-023 SHALL have the compile-time macro CMD_TIMEOUT_EN.
REQ-024 SHALL, with CMD_TIMEOUT_EN defined:
- Count clk cycles while in GOT_L, GOT_IDX, GOT_ACT or DISCARD with rx_valid=0.
- Clear the count on every rx_valid.
- On reaching TIMEOUT_CYCLES, return to IDLE with no response and no LED change.
REQ-025 SHALL, with CMD_TIMEOUT_EN undefined, contain no timeout counter and remain in partial states indefinitely.

Verification
REQ-026 SHALL cover: bytes 'L','2','1',CR with tx_busy=0 -> led=4'b0010 one cycle after CR; single tx_send with tx_data=0x4B; cmd_count=1.
REQ-027 SHALL cover: 'L','2','T',CR twice -> led[1] toggles 1->0; two 'K' responses; cmd_count=3 cumulative.
REQ-028 SHALL cover: 'L','7','1',CR (NUM_LEDS=4) -> led unchanged; tx_data=0x45 sent once; cmd_count unchanged.
REQ-029 SHALL cover: valid command with tx_busy=1 for 50 cycles after CR -> tx_send pulses once, in the first cycle after tx_busy falls; a byte 'L' injected during the wait is ignored.
REQ-030 SHALL cover: 256 valid commands -> cmd_count wraps to 0.
REQ-031 SHALL cover: rst_n low while in GOT_ACT -> no LED change; no tx_send after release.
REQ-032 SHALL cover (CMD_TIMEOUT_EN): 'L','1' then idle for TIMEOUT_CYCLES -> IDLE; a subsequent '1',CR yields 'E'; without the macro, the same '1',CR completes with 'K' and sets led[0].

Source files
------------

// File: rtl/uart_cmd_parser.sv
// ASCII LED command parser ("L<idx><act><CR>") answering 'K' or 'E' over a UART transmitter.
// Define CMD_TIMEOUT_EN to abandon partial commands after TIMEOUT_CYCLES idle clocks.
module uart_cmd_parser #(
  parameter int NUM_LEDS       = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  input  logic                tx_busy,
  output logic                tx_send,
  output logic [7:0]          tx_data,
  output logic [NUM_LEDS-1:0] led,
  output logic [7:0]          cmd_count
);

  localparam logic [7:0] CH_L     = 8'h4C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_T     = 8'h54;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_1     = 8'h31;
  localparam logic [7:0] RESP_OK  = 8'h4B;
  localparam logic [7:0] RESP_ERR = 8'h45;
  localparam int         IW       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  typedef enum logic [2:0] {IDLE, GOT_L, GOT_IDX, GOT_ACT, DISCARD, RESP} state_t;
  typedef enum logic [1:0] {ACT_CLR, ACT_SET, ACT_TGL} act_t;

  state_t        state, state_nxt;
  act_t          act_q, act_nxt;
  logic [IW-1:0] idx_q, idx_nxt;
  logic [7:0]    tx_data_nxt;
  logic          tx_send_nxt;
  logic          exec_cmd;
  logic          idx_ok;
  logic          timeout_hit;

  assign idx_ok = (rx_data >= CH_1) && (rx_data <= (CH_0 + 8'(NUM_LEDS)));

`ifdef CMD_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [CW-1:0] to_cnt;
  logic          partial;

  assign partial     = (state == GOT_L) || (state == GOT_IDX) ||
                       (state == GOT_ACT) || (state == DISCARD);
  assign timeout_hit = partial && !rx_valid && (to_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      to_cnt <= '0;
    else if (rx_valid || !partial || timeout_hit)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + CW'(1);
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx_q;
    act_nxt     = act_q;
    tx_data_nxt = tx_data;
    tx_send_nxt = 1'b0;
    exec_cmd    = 1'b0;
    case (state)
      IDLE:
        if (rx_valid) begin
          if (rx_data == CH_L)                          state_nxt = GOT_L;
          else if (rx_data == CH_CR || rx_data == CH_LF) state_nxt = IDLE;
          else                                          state_nxt = DISCARD;
        end
      GOT_L:
        if (rx_valid) begin
          if (idx_ok) begin
            state_nxt = GOT_IDX;
            idx_nxt   = IW'(rx_data - CH_1);
          end else begin
            state_nxt = DISCARD;
          end
        end
      GOT_IDX:
        if (rx_valid) begin
          state_nxt = GOT_ACT;
          if (rx_data == CH_0)      act_nxt = ACT_CLR;
          else if (rx_data == CH_1) act_nxt = ACT_SET;
          else if (rx_data == CH_T) act_nxt = ACT_TGL;
          else                      state_nxt = DISCARD;
        end
      GOT_ACT:
        if (rx_valid) begin
          if (rx_data == CH_CR) begin
            state_nxt   = RESP;
            tx_data_nxt = RESP_OK;
            exec_cmd    = 1'b1;
          end else begin
            state_nxt = DISCARD;
          end
        end
      DISCARD:
        if (rx_valid && rx_data == CH_CR) begin
          state_nxt   = RESP;
          tx_data_nxt = RESP_ERR;
        end
      RESP:
        // tx_send is registered, so RESP is left only after the pulse has been seen
        if (tx_send)       state_nxt   = IDLE;
        else if (!tx_busy) tx_send_nxt = 1'b1;
      default: state_nxt = IDLE;
    endcase
    if (timeout_hit) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx_q     <= '0;
      act_q     <= ACT_CLR;
      tx_data   <= 8'h00;
      tx_send   <= 1'b0;
      led       <= '0;
      cmd_count <= 8'h00;
    end else begin
      state   <= state_nxt;
      idx_q   <= idx_nxt;
      act_q   <= act_nxt;
      tx_data <= tx_data_nxt;
      tx_send <= tx_send_nxt;
      if (exec_cmd) begin
        cmd_count <= cmd_count + 8'd1;
        case (act_q)
          ACT_CLR: led[idx_q] <= 1'b0;
          ACT_SET: led[idx_q] <= 1'b1;
          default: led[idx_q] <= ~led[idx_q];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: expected response bytes are queued as commands are sent
// and popped by a monitor whenever tx_send fires.
module tb_uart_cmd_parser;

  localparam int NUM_LEDS = 4;
  localparam int TO       = 100;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                rx_valid = 1'b0;
  logic [7:0]          rx_data = 8'h00;
  logic                tx_busy = 1'b0;
  logic                tx_send;
  logic [7:0]          tx_data;
  logic [NUM_LEDS-1:0] led;
  logic [7:0]          cmd_count;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] sb[$];

  uart_cmd_parser #(.NUM_LEDS(NUM_LEDS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .tx_busy(tx_busy),
    .tx_send(tx_send), .tx_data(tx_data), .led(led), .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every tx_send pulse must match the oldest queued response; a pulse with nothing queued is an error
  always @(negedge clk) begin
    if (tx_send !== 1'b0) begin
      if (sb.size() == 0) check_output("unexpected_tx_send", 32'(tx_send), 32'd0);
      else                check_output("tx_data", 32'(tx_data), 32'(sb.pop_front()));
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [7:0] idx, input logic [7:0] act, input logic [7:0] resp);
    send_byte(8'h4C);
    send_byte(idx);
    send_byte(act);
    sb.push_back(resp);
    send_byte(8'h0D);
  endtask

  task automatic wait_response(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_output(tag, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hi;
    #1;
    check_output("rst_led", 32'(led), 32'd0);
    check_output("rst_cmd_count", 32'(cmd_count), 32'd0);
    check_output("rst_tx_send", 32'(tx_send), 32'd0);
    check_output("rst_tx_data", 32'(tx_data), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // L 2 1 CR: set led[1], one-cycle latency, response no earlier than next cycle
    send_byte(8'h4C);
    send_byte(8'h32);
    send_byte(8'h31);
    check_output("led_before_cr", 32'(led), 32'd0);
    sb.push_back(8'h4B);
    send_byte(8'h0D);
    check_output("led_set", 32'(led), 32'b0010);
    check_output("cmd_count_1", 32'(cmd_count), 32'd1);
    check_output("tx_send_latency", 32'(tx_send), 32'd0);
    wait_response("resp_set");

    // Two toggles of led[1]
    apply_stimulus(8'h32, 8'h54, 8'h4B);
    check_output("led_toggle_off", 32'(led), 32'b0000);
    wait_response("resp_tgl1");
    apply_stimulus(8'h32, 8'h54, 8'h4B);
    check_output("led_toggle_on", 32'(led), 32'b0010);
    check_output("cmd_count_3", 32'(cmd_count), 32'd3);
    wait_response("resp_tgl2");

    // Out-of-range index
    apply_stimulus(8'h37, 8'h31, 8'h45);
    wait_response("resp_bad_idx");
    check_output("led_bad_idx", 32'(led), 32'b0010);
    check_output("cmd_count_bad_idx", 32'(cmd_count), 32'd3);

    // Transmitter busy for 50 cycles; an 'L' arriving during the wait must be dropped
    tx_busy = 1'b1;
    apply_stimulus(8'h33, 8'h31, 8'h4B);
    check_output("led_busy_cmd", 32'(led), 32'b0110);
    check_output("cmd_count_4", 32'(cmd_count), 32'd4);
    hi = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_send === 1'b1) hi++;
      if (i == 10) begin rx_valid = 1'b1; rx_data = 8'h4C; end
      if (i == 11) rx_valid = 1'b0;
    end
    check_output("tx_send_while_busy", 32'(hi), 32'd0);
    check_output("tx_data_held", 32'(tx_data), 32'h4B);
    check_output("resp_pending", 32'(sb.size()), 32'd1);
    tx_busy = 1'b0;
    @(negedge clk);
    check_output("tx_send_after_busy", 32'(tx_send), 32'd1);
    @(negedge clk);
    check_output("tx_send_single", 32'(tx_send), 32'd0);
    sb.push_back(8'h45);
    send_byte(8'h31);
    send_byte(8'h31);
    send_byte(8'h0D);
    wait_response("resp_dropped_L");
    check_output("led_after_dropped_L", 32'(led), 32'b0110);

    // 256 toggles spread over all LEDs: counter wraps, LEDs end where they started
    for (int i = 0; i < 256; i++) begin
      apply_stimulus(8'h31 + 8'(i % 4), 8'h54, 8'h4B);
      if (i == 251) check_output("cmd_count_wrap", 32'(cmd_count), 32'd0);
      wait_response("resp_wrap");
    end
    check_output("cmd_count_after_256", 32'(cmd_count), 32'd4);
    check_output("led_after_256", 32'(led), 32'b0110);

    // Reset while in GOT_ACT
    send_byte(8'h4C);
    send_byte(8'h33);
    send_byte(8'h31);
    rst_n = 1'b0;
    #1;
    check_output("midcmd_rst_led", 32'(led), 32'd0);
    check_output("midcmd_rst_cmd_count", 32'(cmd_count), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h0D);
    repeat (10) @(negedge clk);
    check_output("post_rst_led", 32'(led), 32'd0);
    check_output("post_rst_cmd_count", 32'(cmd_count), 32'd0);

    // Stall after 'L','1' longer than the timeout, then finish the command
    send_byte(8'h4C);
    send_byte(8'h31);
    repeat (TO + 20) @(negedge clk);
`ifdef CMD_TIMEOUT_EN
    sb.push_back(8'h45);
    send_byte(8'h31);
    send_byte(8'h0D);
    wait_response("resp_timeout_err");
    check_output("led_timeout", 32'(led), 32'd0);
    check_output("cmd_count_timeout", 32'(cmd_count), 32'd0);
`else
    sb.push_back(8'h4B);
    send_byte(8'h31);
    send_byte(8'h0D);
    wait_response("resp_no_timeout");
    check_output("led_no_timeout", 32'(led), 32'b0001);
    check_output("cmd_count_no_timeout", 32'(cmd_count), 32'd1);
`endif

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
